// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - two-requester multiplier built on one shared external 2x2 digit cell.
// Optional round-robin arbitration with MULT_SHARE_RR_EN; requester 0 has fixed priority otherwise.
module mult_share_ctrl #(
   parameter int OPW = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_a,
   input  logic [OPW-1:0]   req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_a,
   input  logic [OPW-1:0]   req1_b,
   output logic [1:0]       mul_a,
   output logic [1:0]       mul_b,
   input  logic [3:0]       mul_p,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [2*OPW-1:0] rsp_p,
   output logic             busy
);
   localparam int D  = OPW / 2;
   localparam int NS = D * D;
   localparam int KW = $clog2(NS);
   localparam int AW = 2 * OPW;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nx;
   logic [OPW-1:0]  a_r, b_r;
   logic            id_r;
   logic [KW-1:0]   k;
   logic [AW-1:0]   acc;
   logic [KW-1:0]   di, dj;
   logic [AW-1:0]   pp;
   logic            last_step;
   logic            grant;
   logic            hs;

`ifdef MULT_SHARE_RR_EN
   logic last_id;

   // On contention the requester not served most recently wins.
   assign grant = (req0_valid & req1_valid) ? ~last_id : req1_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_id <= 1'b1;
      else if (hs)
         last_id <= grant;
   end
`else
   assign grant = req1_valid & ~req0_valid;
`endif

   assign hs        = (state == IDLE) && (grant ? req1_valid : req0_valid);
   assign di        = KW'(k % KW'(D));
   assign dj        = KW'(k / KW'(D));
   assign last_step = (k == KW'(NS - 1));
   // Digit product weighted by 4^(i+j).
   assign pp        = {{(AW-4){1'b0}}, mul_p} << {di + dj, 1'b0};
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         id_r   <= 1'b0;
         k      <= '0;
         acc    <= '0;
         rsp_id <= 1'b0;
         rsp_p  <= '0;
      end else begin
         state <= state_nx;
         if (hs) begin
            a_r  <= grant ? req1_a : req0_a;
            b_r  <= grant ? req1_b : req0_b;
            id_r <= grant;
            k    <= '0;
            acc  <= '0;
         end else if (state == RUN) begin
            acc <= acc + pp;
            k   <= k + 1'b1;
            if (last_step) begin
               rsp_p  <= acc + pp;
               rsp_id <= id_r;
            end
         end
      end
   end

   always_comb begin
      state_nx   = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      mul_a      = 2'b00;
      mul_b      = 2'b00;
      rsp_valid  = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = ~grant;
            req1_ready = grant;
            if (hs)
               state_nx = RUN;
         end
         RUN: begin
            mul_a = a_r[{di, 1'b0} +: 2];
            mul_b = b_r[{dj, 1'b0} +: 2];
            if (last_step)
               state_nx = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - directed bench for mult_share_ctrl at OPW=4 and OPW=8.
module tb_mult_share_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       r0v, r0r, r1v, r1r;
   logic [3:0] r0a, r0b, r1a, r1b;
   logic [1:0] ma, mb;
   logic [3:0] mp;
   logic       rv, rid, bsy;
   logic [7:0] rp;

   logic       e0v, e0r, e1v, e1r;
   logic [7:0] e0a, e0b, e1a, e1b;
   logic [1:0] ema, emb;
   logic [3:0] emp;
   logic       erv, erid, ebsy;
   logic [15:0] erp;

   assign mp  = {2'b00, ma} * {2'b00, mb};
   assign emp = {2'b00, ema} * {2'b00, emb};

   mult_share_ctrl #(.OPW(4)) dut4 (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
      .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
      .mul_a(ma), .mul_b(mb), .mul_p(mp),
      .rsp_valid(rv), .rsp_id(rid), .rsp_p(rp), .busy(bsy)
   );

   mult_share_ctrl #(.OPW(8)) dut8 (
      .clk(clk), .rst(rst),
      .req0_valid(e0v), .req0_ready(e0r), .req0_a(e0a), .req0_b(e0b),
      .req1_valid(e1v), .req1_ready(e1r), .req1_a(e1a), .req1_b(e1b),
      .mul_a(ema), .mul_b(emb), .mul_p(emp),
      .rsp_valid(erv), .rsp_id(erid), .rsp_p(erp), .busy(ebsy)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       id;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
   } vec_t;

   vec_t vt[8];

   task automatic do_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] p, input string nm);
      int n;
      @(posedge clk); #1;
      if (id) begin r1v = 1'b1; r1a = a; r1b = b; end
      else    begin r0v = 1'b1; r0a = a; r0b = b; end
      #1;
      chk({nm, "_ready"}, id ? r1r : r0r, 1);
      chk({nm, "_other_ready"}, id ? r0r : r1r, 0);
      @(posedge clk); #1;
      r0v = 1'b0; r1v = 1'b0;
      r0a = ~a; r0b = ~b; r1a = ~a; r1b = ~b;
      chk({nm, "_busy"}, bsy, 1);
      chk({nm, "_mul_a0"}, ma, a[1:0]);
      chk({nm, "_mul_b0"}, mb, b[1:0]);
      n = 0;
      while (!rv && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, n, 4);
      chk({nm, "_rsp_id"}, rid, id);
      chk({nm, "_rsp_p"}, rp, p);
      @(posedge clk); #1;
      chk({nm, "_pulse_end"}, rv, 0);
      chk({nm, "_rsp_p_hold"}, rp, p);
      chk({nm, "_idle_busy"}, bsy, 0);
      chk({nm, "_idle_mul"}, {ma, mb}, 0);
   endtask

   task automatic arb_seq();
      int g[$];
      int ids[$];
      int cyc;
      logic seen_r1;
      int exp_g;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      r0v = 1'b1; r0a = 4'd3; r0b = 4'd5;
      r1v = 1'b1; r1a = 4'd6; r1b = 4'd7;
      seen_r1 = 1'b0;
      cyc = 0;
      #1;
      while (ids.size() < 4 && cyc < 80) begin
         if (r0r) g.push_back(0);
         else if (r1r) g.push_back(1);
         if (r1r) seen_r1 = 1'b1;
         if (rv) begin
            ids.push_back(int'(rid));
            chk("arb_rsp_p", rp, rid ? 8'h2A : 8'h0F);
         end
         @(posedge clk); #2;
         cyc++;
      end
      r0v = 1'b0; r1v = 1'b0;
      chk("arb_nrsp", ids.size(), 4);
      chk("arb_ngrant", g.size(), 4);
      for (int i = 0; i < 4 && i < g.size() && i < ids.size(); i++) begin
`ifdef MULT_SHARE_RR_EN
         exp_g = i % 2;
`else
         exp_g = 0;
`endif
         chk($sformatf("arb_grant%0d", i), g[i], exp_g);
         chk($sformatf("arb_rsp_id%0d", i), ids[i], exp_g);
      end
`ifndef MULT_SHARE_RR_EN
      chk("arb_req1_ready_never", seen_r1, 0);
`endif
   endtask

   task automatic rst_mid_run();
      int hits;
      @(posedge clk); #1;
      r0v = 1'b1; r0a = 4'd9; r0b = 4'd7;
      @(posedge clk); #1;
      r0v = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_busy", bsy, 0);
      chk("rst_rsp_valid", rv, 0);
      chk("rst_rsp_p", rp, 0);
      chk("rst_mul", {ma, mb}, 0);
      @(posedge clk); #1 rst = 1'b0;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         if (rv) hits++;
         @(posedge clk); #1;
      end
      chk("rst_no_rsp", hits, 0);
      do_req(1'b0, 4'd2, 4'd2, 8'h04, "post_rst");
   endtask

   task automatic wide_req();
      int n;
      @(posedge clk); #1;
      e0v = 1'b1; e0a = 8'd200; e0b = 8'd171;
      #1;
      chk("w8_ready", e0r, 1);
      @(posedge clk); #1;
      e0v = 1'b0; e0a = 8'd0; e0b = 8'd0;
      n = 0;
      while (!erv && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w8_latency", n, 16);
      chk("w8_rsp_p", erp, 16'h8598);
      chk("w8_rsp_id", erid, 0);
      @(posedge clk); #1;
      chk("w8_pulse_end", erv, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b0, 4'd3,  4'd5,  8'h0F};
      vt[1] = '{1'b1, 4'd15, 4'd15, 8'hE1};
      vt[2] = '{1'b0, 4'd0,  4'd9,  8'h00};
      vt[3] = '{1'b1, 4'd7,  4'd9,  8'h3F};
      vt[4] = '{1'b0, 4'd15, 4'd1,  8'h0F};
      vt[5] = '{1'b1, 4'd10, 4'd12, 8'h78};
      vt[6] = '{1'b0, 4'd8,  4'd8,  8'h40};
      vt[7] = '{1'b0, 4'd2,  4'd2,  8'h04};

      rst = 1'b1;
      r0v = 0; r0a = 0; r0b = 0; r1v = 0; r1a = 0; r1b = 0;
      e0v = 0; e0a = 0; e0b = 0; e1v = 0; e1a = 0; e1b = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", bsy, 0);
      chk("reset_rsp_valid", rv, 0);
      chk("reset_rsp_id", rid, 0);
      chk("reset_rsp_p", rp, 0);
      chk("reset_mul", {ma, mb}, 0);
      chk("reset_w8_rsp_p", erp, 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         do_req(vt[i].id, vt[i].a, vt[i].b, vt[i].p, $sformatf("vec%0d", i));

      arb_seq();
      rst_mid_run();
      wide_req();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
